// File: rtl/plab5_mcore_mem_req_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : plab5_mcore_mem_req_guard_pkg
// Purpose : Shared memory-message field layout for the bank ingress guard.
//           Control words are {type, opaque, addr, len} for requests and
//           {type, opaque, len} for responses, packed MSB first.
//           Also holds the message type encodings and the guard FSM states.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package plab5_mcore_mem_req_guard_pkg;

  localparam int c_TYPE_NBITS = 3;
  localparam int c_LEN_NBITS  = 2;

  // Field LSB offsets inside a control word (len always sits at bit 0)
  localparam int c_LEN_LSB       = 0;
  localparam int c_REQ_ADDR_LSB  = c_LEN_NBITS;
  localparam int c_RESP_OPQ_LSB  = c_LEN_NBITS;

  localparam logic [2:0] c_MSG_TYPE_READ  = 3'd0;
  localparam logic [2:0] c_MSG_TYPE_WRITE = 3'd1;
  localparam logic [2:0] c_MSG_TYPE_INIT  = 3'd2;

  typedef enum logic [0:0] {
    GUARD_IDLE  = 1'b0,
    GUARD_FAULT = 1'b1
  } guard_state_e;

endpackage
`default_nettype wire

// File: rtl/plab5_mcore_mem_guard_queue.sv
`default_nettype none
// ============================================================================
// Module  : plab5_mcore_mem_guard_queue
// Purpose : Circular FIFO of {ctrl, data, domain} request entries.
//           No bypass: an entry is visible at the head the cycle after enqueue.
//           Enqueue is refused whenever full, even if a dequeue happens in
//           the same cycle.
// Ports   : clk, reset (async, active-high)
//           enq_val_i / enq_*_i : push side (accepted when !full_o)
//           deq_i               : pop head (ignored when empty_o)
//           deq_*_o             : head fields
//           full_o / empty_o    : occupancy flags
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module plab5_mcore_mem_guard_queue #(
  parameter int NUM_ENTRIES = 2,
  parameter int CTRL_NBITS  = 45,
  parameter int DATA_NBITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enq_val_i,
  input  logic [CTRL_NBITS-1:0] enq_ctrl_i,
  input  logic [DATA_NBITS-1:0] enq_data_i,
  input  logic                  enq_domain_i,
  input  logic                  deq_i,
  output logic [CTRL_NBITS-1:0] deq_ctrl_o,
  output logic [DATA_NBITS-1:0] deq_data_o,
  output logic                  deq_domain_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int c_PTR_NBITS   = $clog2(NUM_ENTRIES);
  localparam int c_CNT_NBITS   = c_PTR_NBITS + 1;
  localparam int c_ENTRY_NBITS = CTRL_NBITS + DATA_NBITS + 1;

  logic [c_ENTRY_NBITS-1:0] mem_q [NUM_ENTRIES];
  logic [c_PTR_NBITS-1:0]   head_q, head_d;
  logic [c_PTR_NBITS-1:0]   tail_q, tail_d;
  logic [c_CNT_NBITS-1:0]   count_q, count_d;
  logic                     enq_fire, deq_fire;

  assign full_o   = (count_q == c_CNT_NBITS'(NUM_ENTRIES));
  assign empty_o  = (count_q == '0);
  assign enq_fire = enq_val_i && !full_o;
  assign deq_fire = deq_i && !empty_o;

  assign {deq_ctrl_o, deq_data_o, deq_domain_o} = mem_q[head_q];

  // Depth is a power of two, so pointers wrap by natural overflow
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) tail_d = tail_q + 1'b1;
    if (deq_fire) head_d = head_q + 1'b1;
    if (enq_fire && !deq_fire)      count_d = count_q + c_CNT_NBITS'(1);
    else if (!enq_fire && deq_fire) count_d = count_q - c_CNT_NBITS'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q] <= {enq_ctrl_i, enq_data_i, enq_domain_i};
  end

endmodule
`default_nettype wire

// File: rtl/plab5_mcore_mem_req_guard.sv
`default_nettype none
// ============================================================================
// Module  : plab5_mcore_mem_req_guard
// Purpose : Bank-side ingress guard. Buffers domain-tagged requests, blocks
//           non-secure accesses to [p_sec_base, p_sec_bound), answers blocked
//           requests with a zero-data response, and merges those responses
//           with the bank's own responses (alternating on contention).
// Ports   : clk, reset (async, active-high)
//           req_in_*   : requests from the network (val/rdy)
//           req_out_*  : requests to the bank (val/rdy)
//           resp_bank_*: responses from the bank (val/rdy)
//           resp_out_* : merged responses to the network (val/rdy)
//           fault_count: saturating count of blocked requests
// Config  : PLAB5_MCORE_MEM_REQ_GUARD_FAULT_CNT_EN - when defined, fault_count
//           is a real counter; otherwise it is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module plab5_mcore_mem_req_guard
  import plab5_mcore_mem_req_guard_pkg::*;
#(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_num_entries  = 2,
  parameter logic [p_addr_nbits-1:0] p_sec_base  = 32'h0000_8000,
  parameter logic [p_addr_nbits-1:0] p_sec_bound = 32'h0001_0000
) (
  input  logic clk,
  input  logic reset,

  input  logic [c_TYPE_NBITS+p_opaque_nbits+p_addr_nbits+c_LEN_NBITS-1:0] req_in_msg_control,
  input  logic [p_data_nbits-1:0] req_in_msg_data,
  input  logic                    req_in_val,
  output logic                    req_in_rdy,
  input  logic                    req_in_domain,

  output logic [c_TYPE_NBITS+p_opaque_nbits+p_addr_nbits+c_LEN_NBITS-1:0] req_out_msg_control,
  output logic [p_data_nbits-1:0] req_out_msg_data,
  output logic                    req_out_val,
  input  logic                    req_out_rdy,
  output logic                    req_out_domain,

  input  logic [c_TYPE_NBITS+p_opaque_nbits+c_LEN_NBITS-1:0] resp_bank_msg_control,
  input  logic [p_data_nbits-1:0] resp_bank_msg_data,
  input  logic                    resp_bank_val,
  output logic                    resp_bank_rdy,
  input  logic                    resp_bank_domain,

  output logic [c_TYPE_NBITS+p_opaque_nbits+c_LEN_NBITS-1:0] resp_out_msg_control,
  output logic [p_data_nbits-1:0] resp_out_msg_data,
  output logic                    resp_out_val,
  input  logic                    resp_out_rdy,
  output logic                    resp_out_domain,

  output logic [7:0]              fault_count
);

  localparam int c_RQC = c_TYPE_NBITS + p_opaque_nbits + p_addr_nbits + c_LEN_NBITS;
  localparam int c_RSC = c_TYPE_NBITS + p_opaque_nbits + c_LEN_NBITS;
  localparam int c_REQ_OPQ_LSB  = c_REQ_ADDR_LSB + p_addr_nbits;

  // Request queue
  logic                    q_full, q_empty, q_deq;
  logic [c_RQC-1:0]        head_ctrl;
  logic [p_data_nbits-1:0] head_data;
  logic                    head_domain;

  plab5_mcore_mem_guard_queue #(
    .NUM_ENTRIES (p_num_entries),
    .CTRL_NBITS  (c_RQC),
    .DATA_NBITS  (p_data_nbits)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .enq_val_i    (req_in_val),
    .enq_ctrl_i   (req_in_msg_control),
    .enq_data_i   (req_in_msg_data),
    .enq_domain_i (req_in_domain),
    .deq_i        (q_deq),
    .deq_ctrl_o   (head_ctrl),
    .deq_data_o   (head_data),
    .deq_domain_o (head_domain),
    .full_o       (q_full),
    .empty_o      (q_empty)
  );

  assign req_in_rdy = !q_full;

  // Range check on the head
  logic [p_addr_nbits-1:0] head_addr;
  logic                    head_denied;

  assign head_addr   = head_ctrl[c_REQ_ADDR_LSB +: p_addr_nbits];
  assign head_denied = !head_domain && (head_addr >= p_sec_base) && (head_addr < p_sec_bound);

  assign req_out_msg_control = head_ctrl;
  assign req_out_msg_data    = head_data;
  assign req_out_domain      = head_domain;

  // Guard FSM and fault register
  guard_state_e     state_q, state_d;
  logic [c_RSC-1:0] fault_ctrl_q, fault_ctrl_d;
  logic             fault_val, fault_fire;

  assign fault_val = (state_q == GUARD_FAULT);

  always_comb begin
    state_d      = state_q;
    fault_ctrl_d = fault_ctrl_q;
    q_deq        = 1'b0;
    req_out_val  = 1'b0;
    case (state_q)
      GUARD_IDLE: begin
        if (!q_empty) begin
          if (head_denied) begin
            // Pop the denied head now and turn it into a zero-data response
            q_deq        = 1'b1;
            fault_ctrl_d = {head_ctrl[c_RQC-1 -: c_TYPE_NBITS],
                            head_ctrl[c_REQ_OPQ_LSB +: p_opaque_nbits],
                            head_ctrl[c_LEN_LSB +: c_LEN_NBITS]};
            state_d      = GUARD_FAULT;
          end else begin
            req_out_val = 1'b1;
            q_deq       = req_out_rdy;
          end
        end
      end
      GUARD_FAULT: begin
        if (fault_fire) state_d = GUARD_IDLE;
      end
      default: state_d = GUARD_IDLE;
    endcase
  end

  // Response merge. last_fault_q=1 means the fault source was served last,
  // so the bank wins the next contention (reset value favours the bank).
  logic last_fault_q;
  logic grant_bank, grant_fault;

  assign grant_bank  = resp_bank_val && (!fault_val || last_fault_q);
  assign grant_fault = fault_val && !grant_bank;
  assign fault_fire  = grant_fault && resp_out_rdy;

  assign resp_out_val         = grant_bank || grant_fault;
  assign resp_out_msg_control = grant_bank ? resp_bank_msg_control : fault_ctrl_q;
  assign resp_out_msg_data    = grant_bank ? resp_bank_msg_data : '0;
  assign resp_out_domain      = grant_bank ? resp_bank_domain : 1'b0;
  assign resp_bank_rdy        = grant_bank && resp_out_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= GUARD_IDLE;
      fault_ctrl_q <= '0;
      last_fault_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      fault_ctrl_q <= fault_ctrl_d;
      if (resp_out_val && resp_out_rdy) last_fault_q <= grant_fault;
    end
  end

`ifdef PLAB5_MCORE_MEM_REQ_GUARD_FAULT_CNT_EN
  logic [7:0] fault_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_count_q <= 8'h00;
    end else if ((state_q == GUARD_IDLE) && (state_d == GUARD_FAULT) && (fault_count_q != 8'hFF)) begin
      fault_count_q <= fault_count_q + 8'd1;
    end
  end

  assign fault_count = fault_count_q;
`else
  assign fault_count = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/plab5_mcore_mem_req_guard.md
# plab5_mcore_mem_req_guard

Bank-side ingress guard placed directly downstream of the memory request network output port of each bank, between the network and the cache/memory bank. It buffers domain-tagged requests. It blocks non-secure (domain 0) accesses to a configured secure address window and answers blocked requests itself with a zero-data response. It also merges those locally generated responses with the bank's own responses before they enter the response network.

## Interface
- p_opaque_nbits, 8, mem msg opaque width (o)
- p_addr_nbits, 32, mem msg address width (a)
- p_data_nbits, 32, mem msg data width (d)
- p_num_entries, 2, request queue depth (≥2, power of two)
- p_sec_base, 32'h0000_8000, secure window base (inclusive)
- p_sec_bound, 32'h0001_0000, secure window bound (exclusive)
- Derived: rqc = 3+o+a+2 (req control bits), rsc = 3+o+2 (resp control bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_in_msg_control  in  rqc  {type,opaque,addr,len} from request net
- req_in_msg_data  in  d  request write data
- req_in_val / req_in_rdy  in/out  1  net-side request handshake
- req_in_domain  in  1  0 = non-secure, 1 = secure
- req_out_msg_control / req_out_msg_data  out  rqc / d  request to bank
- req_out_val / req_out_rdy  out/in  1  bank request handshake
- req_out_domain  out  1  domain of the presented request
- resp_bank_msg_control / resp_bank_msg_data  in  rsc / d  bank response
- resp_bank_val / resp_bank_rdy  in/out  1  bank response handshake
- resp_bank_domain  in  1  bank response domain
- resp_out_msg_control / resp_out_msg_data  out  rsc / d  response to net
- resp_out_val / resp_out_rdy  out/in  1  net response handshake
- resp_out_domain  out  1  domain of outgoing response
- fault_count  out  8  saturating count of blocked requests

## Operation
- Queue entries hold {control, data, domain}. Enqueue on req_in_val && req_in_rdy. req_in_rdy = (count < p_num_entries) and does not depend on same-cycle dequeue.
- Head address = control[a+1:2]. The head is denied iff domain==0 && p_sec_base ≤ addr < p_sec_bound. Domain 1 is never denied.
- Allowed head: req_out_val=1 and req_out_* = head fields. Dequeue on req_out_rdy.
- Denied head: req_out_val=0. FSM IDLE→FAULT on the denied head while in IDLE. The head is dequeued in that cycle and captured into the fault register as type = request type, opaque copied, len copied, data = 0, domain = 0. While in FAULT the queue head is not presented or popped. FAULT→IDLE when the fault response handshakes.
- Response merge: candidates are the bank response and the fault register (valid in FAULT). When both are valid, grant alternates using a last-grant bit. The winner drives resp_out_*. The loser's rdy is 0. resp_bank_rdy = grant_bank && resp_out_rdy.
- Responses may be reordered relative to requests. Requesters match responses by opaque.
- fault_count increments on each IDLE→FAULT transition and saturates at 8'hFF.

## Timing
- Reset: count=0, FSM=IDLE, last-grant favours bank, fault_count=0, all *_val outputs 0, req_in_rdy=1 on the first cycle after deassert.
- Request latency: an enqueued request is visible at req_out one cycle later. There is no bypass.
- Fault latency: the fault response is valid the cycle after the denied head is popped. Minimum net-in to fault-out is 2 cycles.
- Full queue with a simultaneous dequeue: no enqueue that cycle.
- Pointers wrap modulo p_num_entries.
- An address equal to p_sec_bound is allowed. An address equal to p_sec_base is denied.
- Reset asserted mid-operation discards queued requests and any pending fault response immediately.

## Configuration
- PLAB5_MCORE_MEM_REQ_GUARD_FAULT_CNT_EN defined: the fault_count register is present as above.
- Not defined: fault_count is tied to 8'h00 and no counter flops are synthesized. All other behaviour is identical.

## Structure
- Shared msg-field header holds the req/resp control widths (rqc, rsc), field offsets for type/opaque/addr/len, and the type encodings (read=0, write=1, init=2).
- Sub-module: plab5_mcore_mem_guard_queue holds the parameterized {ctrl,data,domain} FIFO with count, full and empty. The guard holds the range check, FSM, fault register, merge arbiter and counter.

## Test plan
- Secure read: domain=1, read addr 32'h8004, bank returns data 32'hCAFE → req_out fires 1 cycle after accept, resp_out carries 32'hCAFE, fault_count=0.
- Blocked write: domain=0, write addr 32'h8000 opaque 8'h3 → no req_out_val; fault response type=write, opaque=3, data=0 two cycles after accept; fault_count=1.
- Boundaries: domain=0 addr 32'h7FFC and 32'h10000 → both forwarded to bank; addr 32'hFFFC → blocked.
- Backpressure: req_out_rdy=0, send 3 requests → the third waits with req_in_rdy=0 until one dequeue. Then order is preserved.
- Merge contention: the bank response and a fault response are valid together for 4 cycles with resp_out_rdy=1 → grants alternate and neither response is lost.
- Reset mid-FAULT with resp_out_rdy=0 → all val outputs 0 after reset, count=0, and no stale fault response after deassert.
